// File: rtl/imem_boot_loader_pkg.sv
// imem_boot_loader_pkg
// Shared constants for the instruction-memory boot loader:
//   - FSM state encoding (IDLE/LOAD/DRAIN/RUN/ERR)
//   - err_code values (ERR_NONE/ERR_LEN/ERR_TIMEOUT)
//   - default instruction memory depth in bytes
package imem_boot_loader_pkg;

    localparam int DEFAULT_DEPTH = 36;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

endpackage

// File: rtl/imem_boot_loader_timeout.sv
// imem_ld_timeout
// Saturating idle-cycle counter guarding the byte stream during a load.
// Ports:
//   clk     - rising-edge clock
//   rst_n   - synchronous active-low reset
//   clr     - zero the counter (load start or accepted byte)
//   en      - count one idle cycle
//   expired - this idle cycle is the TIMEOUT-th in a row
module imem_ld_timeout #(
    parameter int TIMEOUT = 1024,
    parameter int TW      = 11
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != LIMIT)) begin
            cnt <= cnt + TW'(1);
        end
    end

    // Flags the idle cycle that brings the count to TIMEOUT, so the FSM
    // leaves LOAD on that same edge rather than one cycle later.
    assign expired = en && (cnt >= (LIMIT - TW'(1)));

endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader
// Loads a little-endian byte stream into the byte-addressed instruction
// memory, holding the core in stall until the load completes, then
// releasing it with a one-cycle start pulse.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   ld_start, ld_len    - load request and byte count
//   ld_valid, ld_data   - byte stream input; ld_ready acknowledges
//   mem_we/waddr/wdata  - registered byte write to instruction memory
//   cpu_hold, cpu_start - core stall request and release pulse
//   busy, err, err_code - status (LOAD/DRAIN, ERR state, error reason)
//   ld_sum, ld_count    - mod-256 sum and count of accepted bytes
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int AW      = 6,
    parameter int LW      = 7,
    parameter int TIMEOUT = 1024,
    parameter int TW      = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_start,
    input  logic [LW-1:0] ld_len,
    input  logic          ld_valid,
    input  logic [7:0]    ld_data,
    output logic          ld_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [7:0]    mem_wdata,
    output logic          cpu_hold,
    output logic          cpu_start,
    output logic          busy,
    output logic          err,
    output logic [1:0]    err_code,
    output logic [7:0]    ld_sum,
    output logic [LW-1:0] ld_count
);

    logic [2:0]    state;
    logic [LW-1:0] len_q;
    logic          accept;
    logic          last_byte;
    logic          start_zero;
    logic          start_bad;
    logic          load_go;
    logic          to_expired;

    assign ld_ready  = (state == ST_LOAD);
    assign accept    = ld_valid && ld_ready;
    assign last_byte = accept && ((ld_count + LW'(1)) == len_q);

    // Lengths must be whole words and fit the memory.
    assign start_zero = (ld_len == '0);
    assign start_bad  = (ld_len[1:0] != 2'b00) || (ld_len > LW'(DEPTH));
    assign load_go    = ld_start && !start_zero && !start_bad &&
                        ((state == ST_IDLE) || (state == ST_RUN) || (state == ST_ERR));

    assign cpu_hold = (state != ST_RUN);
    assign busy     = (state == ST_LOAD) || (state == ST_DRAIN);
    assign err      = (state == ST_ERR);

    imem_ld_timeout #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (load_go || accept),
        .en      ((state == ST_LOAD) && !accept),
        .expired (to_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            len_q     <= '0;
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            cpu_start <= 1'b0;
            err_code  <= ERR_NONE;
            ld_sum    <= '0;
            ld_count  <= '0;
        end else begin
            mem_we    <= accept;
            cpu_start <= 1'b0;
            if (accept) begin
                mem_waddr <= ld_count[AW-1:0];
                mem_wdata <= ld_data;
                ld_count  <= ld_count + LW'(1);
                ld_sum    <= ld_sum + ld_data;
            end

            case (state)
                ST_IDLE, ST_RUN, ST_ERR: begin
                    if (ld_start) begin
                        err_code <= ERR_NONE;
                        if (start_zero) begin
                            // Already running: a zero-length request is a no-op.
                            cpu_start <= (state != ST_RUN);
                            state     <= ST_RUN;
                        end else if (start_bad) begin
                            state    <= ST_ERR;
                            err_code <= ERR_LEN;
                        end else begin
                            state    <= ST_LOAD;
                            len_q    <= ld_len;
                            ld_count <= '0;
                            ld_sum   <= '0;
                        end
                    end
                end
                ST_LOAD: begin
                    if (last_byte) begin
                        state <= ST_DRAIN;
                    end else if (to_expired) begin
                        state    <= ST_ERR;
                        err_code <= ERR_TIMEOUT;
                    end
                end
                ST_DRAIN: begin
                    state     <= ST_RUN;
                    cpu_start <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader
// Directed and randomized bench for imem_boot_loader with a behavioural
// reference model of the loader's observable outputs.
module tb_imem_boot_loader;

    localparam int DEPTH   = 36;
    localparam int AW      = 6;
    localparam int LW      = 7;
    localparam int TIMEOUT = 1024;
    localparam int TW      = 11;

    localparam int P_IDLE  = 0;
    localparam int P_LOAD  = 1;
    localparam int P_DRAIN = 2;
    localparam int P_RUN   = 3;
    localparam int P_ERR   = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ld_start;
    logic [LW-1:0] ld_len;
    logic          ld_valid;
    logic [7:0]    ld_data;
    logic          ld_ready;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;
    logic          cpu_hold;
    logic          cpu_start;
    logic          busy;
    logic          err;
    logic [1:0]    err_code;
    logic [7:0]    ld_sum;
    logic [LW-1:0] ld_count;

    imem_boot_loader #(
        .DEPTH   (DEPTH),
        .AW      (AW),
        .LW      (LW),
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_start  (ld_start),
        .ld_len    (ld_len),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .cpu_start (cpu_start),
        .busy      (busy),
        .err       (err),
        .err_code  (err_code),
        .ld_sum    (ld_sum),
        .ld_count  (ld_count)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int   ph      = P_IDLE;
    int   m_len   = 0;
    int   m_count = 0;
    int   m_sum   = 0;
    int   m_idle  = 0;
    int   m_code  = 0;
    int   m_waddr = 0;
    int   m_wdata = 0;
    bit   m_we    = 1'b0;
    bit   m_start = 1'b0;
    int   exp_img [DEPTH];
    logic [7:0] dut_mem [DEPTH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check ready, advance model by the rules, compare all outputs.
    task automatic tick();
        bit acc;
        bit st;
        bit rn;
        int d;
        int len;
        chk("ld_ready", 32'(ld_ready), 32'(ph == P_LOAD));
        rn  = rst_n;
        st  = ld_start;
        len = int'(ld_len);
        d   = int'(ld_data);
        acc = rn && ld_valid && (ph == P_LOAD);
        @(posedge clk);
        #1;
        ld_start = 1'b0;
        m_we     = 1'b0;
        m_start  = 1'b0;
        if (!rn) begin
            ph = P_IDLE; m_count = 0; m_sum = 0; m_code = 0;
            m_waddr = 0; m_wdata = 0; m_idle = 0;
        end else begin
            if (acc) begin
                m_we = 1'b1; m_waddr = m_count; m_wdata = d;
                exp_img[m_count] = d;
                m_count++;
                m_sum  = (m_sum + d) % 256;
                m_idle = 0;
            end
            case (ph)
                P_IDLE, P_RUN, P_ERR: begin
                    if (st) begin
                        m_code = 0;
                        if (len == 0) begin
                            if (ph != P_RUN) m_start = 1'b1;
                            ph = P_RUN;
                        end else if ((len % 4) != 0 || len > DEPTH) begin
                            ph = P_ERR; m_code = 1;
                        end else begin
                            ph = P_LOAD; m_len = len; m_count = 0; m_sum = 0; m_idle = 0;
                        end
                    end
                end
                P_LOAD: begin
                    if (acc) begin
                        if (m_count == m_len) ph = P_DRAIN;
                    end else begin
                        m_idle++;
                        if (m_idle == TIMEOUT) begin
                            ph = P_ERR; m_code = 2;
                        end
                    end
                end
                P_DRAIN: begin
                    ph = P_RUN; m_start = 1'b1;
                end
                default: ph = P_IDLE;
            endcase
        end
        if (mem_we && (int'(mem_waddr) < DEPTH)) dut_mem[mem_waddr] = mem_wdata;
        chk("mem_we",    32'(mem_we),    32'(m_we));
        chk("mem_waddr", 32'(mem_waddr), 32'(m_waddr));
        chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
        chk("cpu_hold",  32'(cpu_hold),  32'(ph != P_RUN));
        chk("cpu_start", 32'(cpu_start), 32'(m_start));
        chk("busy",      32'(busy),      32'(ph == P_LOAD || ph == P_DRAIN));
        chk("err",       32'(err),       32'(ph == P_ERR));
        chk("err_code",  32'(err_code),  32'(m_code));
        chk("ld_sum",    32'(ld_sum),    32'(m_sum));
        chk("ld_count",  32'(ld_count),  32'(m_count));
    endtask

    task automatic drive(input bit v, input logic [7:0] d);
        ld_valid = v;
        ld_data  = d;
        tick();
    endtask

    task automatic start(input int len);
        ld_start = 1'b1;
        ld_len   = LW'(len);
        ld_valid = 1'b0;
        tick();
    endtask

    initial begin
        logic [7:0] nominal [8];
        int n;
        int len;
        nominal[0] = 8'h20; nominal[1] = 8'h10; nominal[2] = 8'h01; nominal[3] = 8'h00;
        nominal[4] = 8'h22; nominal[5] = 8'h30; nominal[6] = 8'h85; nominal[7] = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            exp_img[i] = 0;
            dut_mem[i] = 8'h00;
        end

        rst_n = 1'b0; ld_start = 1'b0; ld_len = '0; ld_valid = 1'b0; ld_data = '0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state, with stimulus active on the inputs
        ld_valid = 1'b1; ld_start = 1'b1; ld_len = LW'(8);
        tick();
        ld_valid = 1'b0;
        rst_n = 1'b1;
        drive(0, 8'h00);

        // Nominal 8-byte load
        start(8);
        for (int i = 0; i < 8; i++) drive(1, nominal[i]);
        drive(0, 8'h00);
        drive(0, 8'h00);
        chk("nominal_sum",   32'(ld_sum),   32'h08);
        chk("nominal_count", 32'(ld_count), 32'd8);

        // Zero length while running: stays in RUN without a pulse
        start(0);
        drive(0, 8'h00);

        // Throttled stream; the fifth valid byte must be refused
        start(4);
        for (int i = 0; i < 9; i++) drive((i % 2) == 0, 8'(8'h41 + i));
        chk("throttle_count", 32'(ld_count), 32'd4);

        // Length errors, then recovery into LOAD
        start(6);
        drive(0, 8'h00);
        start(40);
        drive(0, 8'h00);
        start(4);

        // Timeout after two bytes
        drive(1, 8'hA5);
        drive(1, 8'h5A);
        for (int i = 0; i < TIMEOUT; i++) drive(0, 8'h00);
        chk("timeout_code",  32'(err_code), 32'd2);
        chk("timeout_count", 32'(ld_count), 32'd2);
        drive(0, 8'h00);

        // Reset in the middle of a load, then a clean reload
        start(8);
        for (int i = 0; i < 3; i++) drive(1, 8'(8'hC0 + i));
        rst_n = 1'b0;
        drive(1, 8'hEE);
        rst_n = 1'b1;
        drive(1, 8'hEF);
        start(8);
        for (int i = 0; i < 8; i++) drive(1, 8'($urandom));
        drive(0, 8'h00);
        drive(0, 8'h00);

        // Full-depth reload from RUN
        start(DEPTH);
        for (int i = 0; i < DEPTH; i++) drive(1, 8'($urandom));
        drive(0, 8'h00);
        drive(0, 8'h00);
        for (int i = 0; i < DEPTH; i++) chk("mem_image", 32'(dut_mem[i]), 32'(exp_img[i]));

        // Randomized loads with random throttling
        for (int k = 0; k < 4; k++) begin
            len = 4 * $urandom_range(1, DEPTH / 4);
            start(len);
            n = 0;
            while (ph != P_RUN && n < 2000) begin
                drive($urandom_range(0, 3) != 0, 8'($urandom));
                n++;
            end
            chk("rand_bound", 32'(n < 2000), 32'd1);
            drive(0, 8'h00);
        end

        start(0);
        drive(0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Sequences program loading into the byte-addressed instruction memory before the single-cycle core runs.
- Accepts a byte stream from a host or serial front-end over a valid/ready handshake and issues sequential byte writes, little-endian: byte 4k is bits [7:0] of word k.
- Holds the core in stall until a load completes, then releases it with a one-cycle start pulse.
- Detects bad lengths and stalled streams, and reports an 8-bit additive checksum.

Parameters:
- DEPTH, 36, instruction memory size in bytes; must be a multiple of 4.
- AW, 6, byte address width; 2^AW >= DEPTH.
- LW, 7, length/count width; 2^LW > DEPTH.
- TIMEOUT, 1024, idle cycles allowed between accepted bytes in LOAD before error.
- TW, 11, timeout counter width; 2^TW > TIMEOUT.

Ports:
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, reset, synchronous, active-low.
- ld_start, in, 1, single-cycle request to begin a load.
- ld_len, in, LW, byte count; sampled only in the cycle ld_start is accepted.
- ld_valid, in, 1, ld_data holds a valid byte.
- ld_data, in, 8, program byte.
- ld_ready, out, 1, loader accepts a byte this cycle.
- mem_we, out, 1, registered byte write strobe to instruction memory.
- mem_waddr, out, AW, registered byte write address.
- mem_wdata, out, 8, registered byte write data.
- cpu_hold, out, 1, core stall/hold-in-reset request.
- cpu_start, out, 1, one-cycle pulse when the core is released.
- busy, out, 1, high in LOAD or DRAIN.
- err, out, 1, high in ERR state.
- err_code, out, 2: 0 none, 1 bad length, 2 timeout.
- ld_sum, out, 8, running mod-256 sum of accepted bytes.
- ld_count, out, LW, number of bytes accepted in the current or last load.

Behaviour:
- All state updates on the rising edge. Reset (rst_n=0 at a clock edge) wins over every other input.
- Reset values:
  - State IDLE.
  - cpu_hold=1.
  - All other outputs 0: ld_ready, mem_we, mem_waddr, mem_wdata, cpu_start, busy, err, err_code, ld_sum, ld_count.
- States: IDLE, LOAD, DRAIN, RUN, ERR.
- IDLE:
  - cpu_hold=1.
  - On ld_start:
    - ld_len==0 -> RUN.
    - ld_len[1:0]!=0 or ld_len>DEPTH -> ERR, err_code=1.
    - Otherwise -> LOAD; latch len; clear ld_count, ld_sum and the timeout counter.
- LOAD:
  - ld_ready=1 combinationally.
  - A byte is accepted when ld_valid && ld_ready.
  - Each accept:
    - mem_we=1, mem_waddr=ld_count[AW-1:0], mem_wdata=ld_data in the next cycle (write latency 1 cycle).
    - ld_count+=1, ld_sum+=ld_data (wraps mod 256), timeout counter cleared.
  - When the accept brings ld_count to len -> DRAIN. ld_ready is 0 from the following cycle, so no byte beyond len is ever taken.
  - Cycle with no accept: timeout counter +1. When it reaches TIMEOUT -> ERR, err_code=2. The counter saturates, no wrap.
  - ld_start while in LOAD is ignored.
- DRAIN:
  - One cycle; the final registered write issues here.
  - Next state RUN. cpu_start=1 in the first RUN cycle only.
- RUN:
  - cpu_hold=0, ld_ready=0.
  - ld_start -> same checks as IDLE. cpu_hold=1 in the cycle after the start is accepted.
  - ld_len==0 in RUN -> stay RUN, no cpu_start pulse.
- ERR:
  - cpu_hold=1, err=1, err_code held.
  - Only ld_start leaves it (same checks as IDLE); err and err_code clear on leaving.
- mem_we is 0 in every cycle that does not follow an accepted byte. mem_waddr and mem_wdata hold their last values when mem_we=0.
- ld_count and ld_sum hold their final values after DRAIN or ERR until the next accepted ld_start.
- Reset mid-LOAD: writes stop (mem_we=0 the cycle after the reset edge), return to IDLE with cpu_hold=1. Memory contents are not erased.

Decomposition:
- Shared package (e.g. riscv_pkg):
  - State encoding for IDLE/LOAD/DRAIN/RUN/ERR.
  - err_code constants ERR_NONE/ERR_LEN/ERR_TIMEOUT.
  - Default DEPTH.
- One natural sub-module: imem_ld_timeout, a saturating idle counter with clear/enable/expired outputs. Everything else stays in the top FSM.

Test Plan:
- Nominal load: ld_start, ld_len=8, bytes 20,10,01,00,22,30,85,00 back-to-back. Expect:
  - mem writes to addresses 0..7, each one cycle after its accept.
  - ld_count=8, ld_sum=8'h08.
  - DRAIN, then cpu_start pulse; cpu_hold falls in the same cycle.
- Throttled stream: ld_len=4 with ld_valid toggling every other cycle. Expect exactly 4 writes at addresses 0..3, no write on invalid cycles; a 5th valid byte is left unaccepted (ld_ready=0).
- Length errors:
  - ld_len=6 -> ERR, err_code=1, no mem_we.
  - ld_len=40 -> ERR, err_code=1.
  - Then ld_start with ld_len=4 -> LOAD, err clears.
- Timeout: ld_len=4, supply 2 bytes, then ld_valid=0 for TIMEOUT cycles. Expect ERR, err_code=2, ld_count=2, cpu_hold=1.
- Reset mid-load: assert rst_n=0 after byte 3 of 8. Expect all outputs at reset values the next cycle, cpu_hold=1, no further writes, then a clean reload.
- Reload from RUN and zero length:
  - In RUN, ld_start with ld_len=DEPTH=36: cpu_hold=1, 36 writes, last at address 35, then cpu_start.
  - In RUN, ld_start with ld_len=0: stays RUN, no cpu_start pulse.
